// File: rtl/approx_mon_pkg.sv
// Shared types and default sizing for the approximate-circuit error monitor.
// The FSM state encoding lives here so the top and any future siblings agree on it.
package approx_mon_pkg;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_OUT_W = 3;
    localparam int DEF_ET    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/abs_err_unit.sv
// Combinational unsigned absolute difference of two CUT output words,
// plus a flag that the difference exceeds the error threshold.
module abs_err_unit
    import approx_mon_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int ET    = DEF_ET
) (
    input  logic [OUT_W-1:0] a_i,
    input  logic [OUT_W-1:0] b_i,
    output logic [OUT_W-1:0] diff_o,
    output logic             gt_et_o
);

    // Subtract in the direction that cannot underflow.
    assign diff_o  = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    assign gt_et_o = (int'(diff_o) > ET);

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustively sweeps all 2^N_IN input vectors of an exact/approximate CUT pair
// and accumulates max error, error sum, violation count and first violating vector.
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ET    = DEF_ET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N_IN-1:0]       vec,
    input  logic [OUT_W-1:0]      exact_val,
    input  logic [OUT_W-1:0]      approx_val,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      max_err,
    output logic [OUT_W+N_IN-1:0] err_sum,
    output logic [N_IN:0]         viol_cnt,
    output logic [N_IN-1:0]       first_viol_vec,
    output logic                  first_viol_valid,
    output logic                  pass
);

    localparam int              ERR_W    = OUT_W + N_IN;
    localparam int              VC_W     = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    mon_state_t state_q;
    logic       busy_q, done_q;

    logic [N_IN-1:0]  vec_q, vec_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_diff_q, s1_diff_d;
    logic             s1_gt_q, s1_gt_d;
    logic [N_IN-1:0]  s1_vec_q, s1_vec_d;

    logic [OUT_W-1:0] max_err_q, max_err_d;
    logic [ERR_W-1:0] err_sum_q, err_sum_d;
    logic [VC_W-1:0]  viol_cnt_q, viol_cnt_d;
    logic [N_IN-1:0]  fv_vec_q, fv_vec_d;
    logic             fv_valid_q, fv_valid_d;

    logic [OUT_W-1:0] abs_diff;
    logic             abs_gt;
    logic             start_acc;
    logic             sweep_step;

    abs_err_unit #(
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_abs_err (
        .a_i     (exact_val),
        .b_i     (approx_val),
        .diff_o  (abs_diff),
        .gt_et_o (abs_gt)
    );

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign sweep_step = (state_q == ST_SWEEP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SWEEP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (vec_q == VEC_LAST) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every _d gets a hold default first so no path through this block
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        vec_d      = vec_q;
        s1_valid_d = 1'b0;
        s1_diff_d  = s1_diff_q;
        s1_gt_d    = s1_gt_q;
        s1_vec_d   = s1_vec_q;
        max_err_d  = max_err_q;
        err_sum_d  = err_sum_q;
        viol_cnt_d = viol_cnt_q;
        fv_vec_d   = fv_vec_q;
        fv_valid_d = fv_valid_q;

        if (start_acc) begin
            vec_d      = '0;
            max_err_d  = '0;
            err_sum_d  = '0;
            viol_cnt_d = '0;
            fv_vec_d   = '0;
            fv_valid_d = 1'b0;
        end else begin
            // Stage 1: capture this vector's error; vec parks on the last value.
            if (sweep_step) begin
                s1_valid_d = 1'b1;
                s1_diff_d  = abs_diff;
                s1_gt_d    = abs_gt;
                s1_vec_d   = vec_q;
                if (vec_q != VEC_LAST) vec_d = vec_q + 1'b1;
            end
            // Stage 2: fold the previous vector's error into the results.
            if (s1_valid_q) begin
                err_sum_d = err_sum_q + ERR_W'(s1_diff_q);
                if (s1_diff_q > max_err_q) max_err_d = s1_diff_q;
                if (s1_gt_q) begin
                    viol_cnt_d = viol_cnt_q + VC_W'(1);
                    if (!fv_valid_q) begin
                        fv_vec_d   = s1_vec_q;
                        fv_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_gt_q    <= 1'b0;
            s1_vec_q   <= '0;
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
            fv_vec_q   <= '0;
            fv_valid_q <= 1'b0;
        end else begin
            vec_q      <= vec_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_gt_q    <= s1_gt_d;
            s1_vec_q   <= s1_vec_d;
            max_err_q  <= max_err_d;
            err_sum_q  <= err_sum_d;
            viol_cnt_q <= viol_cnt_d;
            fv_vec_q   <= fv_vec_d;
            fv_valid_q <= fv_valid_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign max_err          = max_err_q;
    assign err_sum          = err_sum_q;
    assign viol_cnt         = viol_cnt_q;
    assign first_viol_vec   = fv_vec_q;
    assign first_viol_valid = fv_valid_q;
    assign pass             = (viol_cnt_q == '0);

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor: a behavioural CUT pair selected by
// 'mode' feeds the monitor; each scenario task checks hand-computed results.
module tb_approx_error_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vec;
    logic [2:0] exact_val, approx_val;
    logic       busy, done;
    logic [2:0] max_err;
    logic [6:0] err_sum;
    logic [4:0] viol_cnt;
    logic [3:0] first_viol_vec;
    logic       first_viol_valid;
    logic       pass;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         mode    = 0;
    logic [2:0] mm_diff = 3'd0;

    always #5 clk = ~clk;

    approx_error_monitor #(.N_IN(4), .OUT_W(3), .ET(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .vec              (vec),
        .exact_val        (exact_val),
        .approx_val       (approx_val),
        .busy             (busy),
        .done             (done),
        .max_err          (max_err),
        .err_sum          (err_sum),
        .viol_cnt         (viol_cnt),
        .first_viol_vec   (first_viol_vec),
        .first_viol_valid (first_viol_valid),
        .pass             (pass)
    );

    // Behavioural CUT pair: 0 = identical, 1 = exact vec[2:0] vs zero, 2 = single mismatch at vec 9.
    always_comb begin
        exact_val  = 3'd0;
        approx_val = 3'd0;
        case (mode)
            0: begin
                exact_val  = vec[2:0];
                approx_val = vec[2:0];
            end
            1: exact_val = vec[2:0];
            default: if (vec == 4'd9) exact_val = mm_diff;
        endcase
    end

    // Accept a start at edge 0, then run 30 more edges; optional re-pulse of start at edge pulse_at.
    task automatic do_sweep(input int pulse_at, output int lat, output int n_done);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = -1; n_done = 0;
        for (int i = 1; i <= 30; i++) begin
            start = (i == pulse_at);
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (lat < 0) lat = i;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
        n_tests++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); n_fail++; end
        n_tests++; if (vec !== 4'd0) begin $display("FAIL reset_vec: got %0d want 0", vec); n_fail++; end
        n_tests++; if ({max_err, err_sum, viol_cnt, first_viol_vec, first_viol_valid} !== 20'd0) begin
            $display("FAIL reset_results: got %h want 0", {max_err, err_sum, viol_cnt, first_viol_vec, first_viol_valid}); n_fail++; end
        n_tests++; if (pass !== 1'b1) begin $display("FAIL reset_pass: got %b want 1", pass); n_fail++; end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tied();
        int lat, nd;
        mode = 0;
        do_sweep(-1, lat, nd);
        n_tests++; if (lat !== 17) begin $display("FAIL tied_latency: got %0d want 17", lat); n_fail++; end
        n_tests++; if (nd !== 1) begin $display("FAIL tied_done_count: got %0d want 1", nd); n_fail++; end
        n_tests++; if (max_err !== 3'd0) begin $display("FAIL tied_max_err: got %0d want 0", max_err); n_fail++; end
        n_tests++; if (err_sum !== 7'd0) begin $display("FAIL tied_err_sum: got %0d want 0", err_sum); n_fail++; end
        n_tests++; if (viol_cnt !== 5'd0) begin $display("FAIL tied_viol_cnt: got %0d want 0", viol_cnt); n_fail++; end
        n_tests++; if (pass !== 1'b1) begin $display("FAIL tied_pass: got %b want 1", pass); n_fail++; end
        n_tests++; if (first_viol_valid !== 1'b0) begin $display("FAIL tied_fvv: got %b want 0", first_viol_valid); n_fail++; end
    endtask

    task automatic test_ramp();
        int lat, nd;
        mode = 1;
        do_sweep(-1, lat, nd);
        n_tests++; if (lat !== 17) begin $display("FAIL ramp_latency: got %0d want 17", lat); n_fail++; end
        n_tests++; if (max_err !== 3'd7) begin $display("FAIL ramp_max_err: got %0d want 7", max_err); n_fail++; end
        n_tests++; if (err_sum !== 7'd56) begin $display("FAIL ramp_err_sum: got %0d want 56", err_sum); n_fail++; end
        n_tests++; if (viol_cnt !== 5'd6) begin $display("FAIL ramp_viol_cnt: got %0d want 6", viol_cnt); n_fail++; end
        n_tests++; if (first_viol_vec !== 4'd5 || first_viol_valid !== 1'b1) begin
            $display("FAIL ramp_first_viol: got %0d/%b want 5/1", first_viol_vec, first_viol_valid); n_fail++; end
        n_tests++; if (pass !== 1'b0) begin $display("FAIL ramp_pass: got %b want 0", pass); n_fail++; end
        n_tests++; if (vec !== 4'd15) begin $display("FAIL ramp_vec_hold: got %0d want 15", vec); n_fail++; end
    endtask

    task automatic test_threshold();
        int lat, nd;
        mode = 2; mm_diff = 3'd4;
        do_sweep(-1, lat, nd);
        n_tests++; if (viol_cnt !== 5'd0) begin $display("FAIL thr_eq_viol_cnt: got %0d want 0", viol_cnt); n_fail++; end
        n_tests++; if (pass !== 1'b1) begin $display("FAIL thr_eq_pass: got %b want 1", pass); n_fail++; end
        n_tests++; if (max_err !== 3'd4 || err_sum !== 7'd4) begin
            $display("FAIL thr_eq_err: got max %0d sum %0d want 4 4", max_err, err_sum); n_fail++; end
        mm_diff = 3'd5;
        do_sweep(-1, lat, nd);
        n_tests++; if (viol_cnt !== 5'd1) begin $display("FAIL thr_gt_viol_cnt: got %0d want 1", viol_cnt); n_fail++; end
        n_tests++; if (first_viol_vec !== 4'd9 || first_viol_valid !== 1'b1) begin
            $display("FAIL thr_gt_first_viol: got %0d/%b want 9/1", first_viol_vec, first_viol_valid); n_fail++; end
        n_tests++; if (pass !== 1'b0) begin $display("FAIL thr_gt_pass: got %b want 0", pass); n_fail++; end
    endtask

    task automatic test_restart_ignored();
        int lat, nd;
        mode = 1;
        do_sweep(5, lat, nd);
        n_tests++; if (lat !== 17) begin $display("FAIL restart_latency: got %0d want 17", lat); n_fail++; end
        n_tests++; if (nd !== 1) begin $display("FAIL restart_done_count: got %0d want 1", nd); n_fail++; end
        n_tests++; if ({max_err, err_sum, viol_cnt, first_viol_vec} !== {3'd7, 7'd56, 5'd6, 4'd5}) begin
            $display("FAIL restart_results: got %0d %0d %0d %0d want 7 56 6 5", max_err, err_sum, viol_cnt, first_viol_vec); n_fail++; end
    endtask

    task automatic test_reset_mid();
        int lat, nd, seen;
        mode = 1; seen = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        n_tests++; if (busy !== 1'b0 || vec !== 4'd0) begin
            $display("FAIL midrst_state: got busy %b vec %0d want 0 0", busy, vec); n_fail++; end
        n_tests++; if ({max_err, err_sum, viol_cnt, first_viol_vec, first_viol_valid} !== 20'd0 || pass !== 1'b1) begin
            $display("FAIL midrst_results: got %h pass %b want 0 pass 1", {max_err, err_sum, viol_cnt, first_viol_vec, first_viol_valid}, pass); n_fail++; end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_tests++; if (seen !== 0) begin $display("FAIL midrst_no_done: got %0d activity cycles want 0", seen); n_fail++; end
        do_sweep(-1, lat, nd);
        n_tests++; if (lat !== 17 || viol_cnt !== 5'd6) begin
            $display("FAIL midrst_fresh: got lat %0d viol %0d want 17 6", lat, viol_cnt); n_fail++; end
    endtask

    task automatic test_back_to_back();
        int d[$];
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                d.push_back(i);
                n_tests++; if (viol_cnt !== 5'd6 || err_sum !== 7'd56) begin
                    $display("FAIL b2b_results_%0d: got viol %0d sum %0d want 6 56", i, viol_cnt, err_sum); n_fail++; end
            end
            if (i == 18) begin
                n_tests++; if (err_sum !== 7'd56) begin $display("FAIL b2b_hold: got %0d want 56", err_sum); n_fail++; end
            end
            if (i == 19) begin
                n_tests++; if (err_sum !== 7'd0 || busy !== 1'b1) begin
                    $display("FAIL b2b_clear: got sum %0d busy %b want 0 1", err_sum, busy); n_fail++; end
            end
        end
        start = 1'b0;
        n_tests++; if (d.size() !== 3) begin $display("FAIL b2b_done_count: got %0d want 3", d.size()); n_fail++; end
        else begin
            n_tests++; if (d[0] !== 17 || d[1] - d[0] !== 19 || d[2] - d[1] !== 19) begin
                $display("FAIL b2b_spacing: got %0d %0d %0d want 17 36 55", d[0], d[1], d[2]); n_fail++; end
        end
        repeat (25) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        test_reset();
        test_tied();
        test_ramp();
        test_threshold();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
